rr_arbiter_n: RTL and testbench

- Parametrised N-requester round-robin arbiter; successor to the two-requester arbiter FSM.
- Mealy grant: a request is granted in the same cycle it is seen, and the current owner keeps the grant while its request stays high.
- Priority rotates to the requester after the last grantee.
- Sits between N bus masters and one shared resource.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 50 +++++
 rtl/rr_arbiter_n.sv | 113 +++++++++++
 tb/tb_rr_arbiter_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared helpers and defaults for the N-requester round-robin arbiter.
//   clog2_min1     - ceil(log2(n)), never less than 1 (width of an index field)
//   onehot_to_idx  - binary index of a one-hot vector (up to 16 bits); 0 when empty
//   ARB_N_DEF / ARB_MAX_HOLD_DEF - default parameter values
package arb_pkg;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;
  localparam int ARB_N_MAX        = 16;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // OR-based encoder: a zero vector yields 0, and only set bits contribute,
  // so the result is never X for a known input.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N_MAX; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick.
//   req[N]      request vector
//   ptr[IDX_W]  index that has highest priority this cycle
//   mask[N]     requesters excluded from the pick
//   onehot[N]   one-hot winner, all-zero when nothing eligible
//   idx[IDX_W]  binary winner index, 0 when nothing eligible
//   vld         a winner exists
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = ARB_N_DEF,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  logic [N-1:0]   eligible;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] below_ptr;
  logic [2*N-1:0] dbl_masked;

  assign eligible  = req & ~mask;
  assign dbl       = {eligible, eligible};
  // Clearing the lower copy below ptr makes the lowest remaining set bit the
  // first requester at or after ptr; the upper copy supplies the wrap-around.
  assign below_ptr  = (2*N)'((64'd1 << ptr) - 64'd1);
  assign dbl_masked = dbl & ~below_ptr;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl_masked[j]) begin
        vld = 1'b1;
        idx = IDX_W'(j % N);
      end
    end
  end

  always_comb begin
    onehot = '0;
    if (vld) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester round-robin arbiter with Mealy grant and owner hold.
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset; also forces the grant to zero
//   req[N]     request vector, bit i = requester i
//   grant[N]   one-hot grant, all-zero when none
//   grant_vld  OR of grant
//   grant_idx  binary index of the granted requester, 0 when none
// Optional feature macro: ARB_TIMEOUT_EN -- force a handoff after MAX_HOLD
// consecutive owned cycles when another requester is waiting.
//
// state     | meaning
// IDLE(ptr) | own_vld=0, no grant; next pick starts at ptr
// OWN(i)    | own_vld=1, requester i holds while req[i] stays high
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int IDX_W    = clog2_min1(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_vld,
  output logic [IDX_W-1:0] grant_idx
);

  if (N < 2 || N > ARB_N_MAX || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter_n: N must be 2..16 and MAX_HOLD >= 1");
  end

  logic [IDX_W-1:0] ptr;
  logic             own_vld;
  logic [IDX_W-1:0] own_idx;

  logic [N-1:0]     own_oh;
  logic [N-1:0]     pick_mask;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             hold;
  logic             timeout;

  always_comb begin
    own_oh = '0;
    own_oh[own_idx] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TEN_W = clog2_min1(MAX_HOLD + 1);

  logic [TEN_W-1:0] tenure;

  // Only force a handoff when someone else is actually waiting.
  assign timeout = own_vld && (tenure == TEN_W'(MAX_HOLD)) &&
                   ((req & ~own_oh) != '0);
`else
  assign timeout = 1'b0;
`endif

  assign hold      = own_vld && req[own_idx] && !timeout;
  assign pick_mask = timeout ? own_oh : '0;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mask   (pick_mask),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  always_comb begin
    grant = '0;
    if (!reset) grant = hold ? own_oh : pick_oh;
  end

  assign grant_vld = |grant;
  assign grant_idx = IDX_W'(onehot_to_idx(16'(grant)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      own_vld <= 1'b0;
      own_idx <= '0;
    end else if (grant_vld) begin
      own_vld <= 1'b1;
      own_idx <= grant_idx;
      ptr     <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      own_vld <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tenure <= '0;
    end else if (!grant_vld) begin
      tenure <= '0;
    end else if (own_vld && (grant_idx == own_idx)) begin
      if (tenure != TEN_W'(MAX_HOLD)) tenure <= tenure + 1'b1;
    end else begin
      tenure <= TEN_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
module tb_rr_arbiter_n;

  localparam int N4  = 4;
  localparam int MH4 = 4;
  localparam int N2  = 2;
  localparam int MH2 = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst4, rst2;
  logic [3:0] req4;
  logic [1:0] req2;
  logic [3:0] grant4;
  logic       vld4;
  logic [1:0] idx4;
  logic [1:0] grant2;
  logic       vld2;
  logic       idx2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter_n #(.N(N4), .MAX_HOLD(MH4)) dut4 (
    .clk       (clk),
    .reset     (rst4),
    .req       (req4),
    .grant     (grant4),
    .grant_vld (vld4),
    .grant_idx (idx4)
  );

  rr_arbiter_n #(.N(N2), .MAX_HOLD(MH2)) dut2 (
    .clk       (clk),
    .reset     (rst2),
    .req       (req2),
    .grant     (grant2),
    .grant_vld (vld2),
    .grant_idx (idx2)
  );

  // Reference model: owner index (-1 = none), priority start, tenure count.
  int m_own[2] = '{-1, -1};
  int m_ptr[2] = '{0, 0};
  int m_ten[2] = '{0, 0};

  // Winner index under the arbitration rules, or -1 for no grant.
  function automatic int pick(int n, int mh, int own, int ptr, int ten,
                              logic rs, logic [15:0] r);
    bit to;
    if (rs) return -1;
    to = TO_EN && (own >= 0) && (ten == mh) && ((r & ~(16'd1 << own)) != 16'd0);
    if (own >= 0 && r[own] && !to) return own;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (r[i] && !(to && i == own)) return i;
    end
    return -1;
  endfunction

  task automatic model_step(int u, int n, int mh, logic [15:0] r);
    int g;
    g = pick(n, mh, m_own[u], m_ptr[u], m_ten[u], 1'b0, r);
    if (g >= 0) begin
      m_ten[u] = (m_own[u] == g) ? ((m_ten[u] + 1 > mh) ? mh : m_ten[u] + 1) : 1;
      m_own[u] = g;
      m_ptr[u] = (g + 1) % n;
    end else begin
      m_own[u] = -1;
      m_ten[u] = 0;
    end
  endtask

  always @(posedge clk or posedge rst4) begin
    if (rst4) begin
      m_own[0] = -1; m_ptr[0] = 0; m_ten[0] = 0;
    end else begin
      model_step(0, N4, MH4, 16'(req4));
    end
  end

  always @(posedge clk or posedge rst2) begin
    if (rst2) begin
      m_own[1] = -1; m_ptr[1] = 0; m_ten[1] = 0;
    end else begin
      model_step(1, N2, MH2, 16'(req2));
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e4, e2;
    e4 = pick(N4, MH4, m_own[0], m_ptr[0], m_ten[0], rst4, 16'(req4));
    chk("m4_grant", 32'(grant4), (e4 < 0) ? 32'd0 : (32'd1 << e4));
    chk("m4_vld",   32'(vld4),   (e4 >= 0) ? 32'd1 : 32'd0);
    chk("m4_idx",   32'(idx4),   (e4 < 0) ? 32'd0 : 32'(e4));
    e2 = pick(N2, MH2, m_own[1], m_ptr[1], m_ten[1], rst2, 16'(req2));
    chk("m2_grant", 32'(grant2), (e2 < 0) ? 32'd0 : (32'd1 << e2));
    chk("m2_vld",   32'(vld2),   (e2 >= 0) ? 32'd1 : 32'd0);
    chk("m2_idx",   32'(idx2),   (e2 < 0) ? 32'd0 : 32'(e2));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic       v_rst[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1};
  logic [1:0] v_req[23] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                            2'b01, 2'b10, 2'b10, 2'b01, 2'b10,
                            2'b00, 2'b00, 2'b10, 2'b10, 2'b00,
                            2'b10, 2'b01, 2'b01, 2'b00, 2'b10,
                            2'b00, 2'b01, 2'b00};
  logic [1:0] v_gnt[23] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                            2'b01, 2'b10, 2'b10, 2'b01, 2'b10,
                            2'b00, 2'b00, 2'b10, 2'b10, 2'b00,
                            2'b10, 2'b01, 2'b01, 2'b00, 2'b10,
                            2'b00, 2'b01, 2'b00};

  initial begin
    rst4 = 1'b1; req4 = 4'b1111;
    rst2 = 1'b1; req2 = 2'b00;
    #1;
    chk("rst_grant", 32'(grant4), 32'h0);
    chk("rst_vld",   32'(vld4),   32'h0);
    tick();

    rst4 = 1'b0; req4 = 4'b0001;
    #1;
    chk("first_grant", 32'(grant4), 32'h1);
    chk("first_idx",   32'(idx4),   32'h0);
    tick();

    req4 = 4'b1111;
    repeat (3) begin
      #1 chk("hold0", 32'(grant4), 32'h1);
      tick();
    end

    req4 = 4'b1110;
    #1;
    chk("handoff_grant", 32'(grant4), 32'h2);
    chk("handoff_idx",   32'(idx4),   32'h1);
    tick();

    // ptr must now be 2: with 0 and 2 requesting, 2 wins.
    req4 = 4'b0101;
    #1 chk("ptr2_pick", 32'(grant4), 32'h4);
    tick();

    req4 = 4'b0000;
    repeat (3) begin
      #1 chk("idle", 32'(grant4), 32'h0);
      tick();
    end

    req4 = 4'b0011;
    #1 chk("wrap_pick", 32'(grant4), 32'h1);
    tick();

    rst4 = 1'b1; req4 = 4'b0000;
    tick();
    rst4 = 1'b0;
    tick();
    req4 = 4'b0101;
    for (int c = 0; c < 22; c++) begin
      #1;
`ifdef ARB_TIMEOUT_EN
      if (c < 5) chk("timeout_seq", 32'(grant4), (c < 4) ? 32'h1 : 32'h4);
`else
      chk("hold_long", 32'(grant4), 32'h1);
`endif
      tick();
    end

    req4 = 4'b1000;
    #1 chk("own3", 32'(grant4), 32'h8);
    tick();
    #1 rst4 = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(grant4), 32'h0);
    chk("rst_mid_vld",   32'(vld4),   32'h0);
    chk("rst_mid_idx",   32'(idx4),   32'h0);
    tick();
    rst4 = 1'b0; req4 = 4'b1010;
    #1 chk("after_rst", 32'(grant4), 32'h2);
    tick();
    req4 = 4'b0000;

    for (int i = 0; i < 23; i++) begin
      rst2 = v_rst[i];
      req2 = v_req[i];
      #1 chk($sformatf("n2_vec%0d", i), 32'(grant2), 32'(v_gnt[i]));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
